// File: rtl/imm_encoder_if.sv
// Instruction-type encoding and the valid/ready bus of the immediate encoder:
// an input beat {type, imm, base} and an output beat {inst, err}.
package imm_encoder_pkg;
  typedef enum logic [2:0] {
    INST_TYPE_I = 3'd0,
    INST_TYPE_S = 3'd1,
    INST_TYPE_B = 3'd2,
    INST_TYPE_U = 3'd3,
    INST_TYPE_J = 3'd4
  } InstructionType;
endpackage

interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic           in_valid;
  logic           in_ready;
  InstructionType in_type;
  logic [31:0]    in_imm;
  logic [31:0]    in_base;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_inst;
  logic           out_err;

  modport master (
    output in_valid, in_type, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_type, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: scatters a 32-bit immediate into the RV32I
// fields of a base instruction word and flags values the type cannot hold.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  imm_encoder_if.slave         bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic           a_valid;
  InstructionType a_type;
  logic [31:0]    a_imm;
  logic [31:0]    a_base;

  logic           b_valid;
  logic [31:0]    b_inst;
  logic           b_err;

  logic           a_ready;
  logic           b_ready;
  logic [31:0]    enc_inst;
  logic           enc_err;

  // Ready ripples combinationally from out_ready back to in_ready.
  assign b_ready       = !b_valid || bus.out_ready;
  assign a_ready       = !a_valid || b_ready;
  assign bus.in_ready  = a_ready;
  assign bus.out_valid = b_valid;
  assign bus.out_inst  = b_inst;
  assign bus.out_err   = b_err;

  function automatic logic all_eq21(input logic [20:0] v);
    return (&v) || (~|v);
  endfunction

  always_comb begin
    enc_inst = a_base;
    enc_err  = 1'b0;
    case (a_type)
      INST_TYPE_I: begin
        enc_inst[31:20] = a_imm[11:0];
        enc_err         = !all_eq21(a_imm[31:11]);
      end
      INST_TYPE_S: begin
        enc_inst[31:25] = a_imm[11:5];
        enc_inst[11:7]  = a_imm[4:0];
        enc_err         = !all_eq21(a_imm[31:11]);
      end
      INST_TYPE_B: begin
        enc_inst[31]    = a_imm[12];
        enc_inst[7]     = a_imm[11];
        enc_inst[30:25] = a_imm[10:5];
        enc_inst[11:8]  = a_imm[4:1];
        enc_err         = a_imm[0] || !((&a_imm[31:12]) || (~|a_imm[31:12]));
      end
      INST_TYPE_U: begin
        enc_inst[31:12] = a_imm[31:12];
        enc_err         = |a_imm[11:0];
      end
      INST_TYPE_J: begin
        enc_inst[31]    = a_imm[20];
        enc_inst[19:12] = a_imm[19:12];
        enc_inst[20]    = a_imm[11];
        enc_inst[30:21] = a_imm[10:1];
        enc_err         = a_imm[0] || !((&a_imm[31:20]) || (~|a_imm[31:20]));
      end
      default: begin
        enc_inst = a_base;
        enc_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_type    <= INST_TYPE_I;
      a_imm     <= '0;
      a_base    <= '0;
      b_valid   <= 1'b0;
      b_inst    <= '0;
      b_err     <= 1'b0;
      err_count <= '0;
    end else begin
      if (a_ready) begin
        a_valid <= bus.in_valid;
        if (bus.in_valid) begin
          a_type <= bus.in_type;
          a_imm  <= bus.in_imm;
          a_base <= bus.in_base;
        end
      end
      if (b_ready) begin
        b_valid <= a_valid;
        if (a_valid) begin
          b_inst <= enc_inst;
          b_err  <= enc_err;
        end
      end
      if (b_valid && bus.out_ready && b_err && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors plus a round-trip sweep.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int unsigned CW = 4;

  typedef struct {
    logic           rt;
    InstructionType t;
    logic [31:0]    imm;
    logic [31:0]    inst;
    logic           err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] err_count;
  imm_encoder_if bus();

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int unsigned   exp_cnt = 0;

  imm_encoder #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] immgen(input InstructionType t, input logic [31:0] i);
    case (t)
      INST_TYPE_I: return {{20{i[31]}}, i[31:20]};
      INST_TYPE_S: return {{20{i[31]}}, i[31:25], i[11:7]};
      INST_TYPE_B: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      INST_TYPE_U: return {i[31:12], 12'b0};
      INST_TYPE_J: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:     return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", bus.out_inst, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rt) begin
          check("roundtrip_imm", immgen(e.t, bus.out_inst), e.imm);
          check("roundtrip_err", {31'b0, bus.out_err}, 32'h0);
        end else begin
          check("out_inst", bus.out_inst, e.inst);
          check("out_err", {31'b0, bus.out_err}, {31'b0, e.err});
          if (e.err && exp_cnt < (2**CW - 1)) exp_cnt++;
        end
      end
    end
  end

  task automatic send(input InstructionType t, input logic [31:0] imm, input logic [31:0] base,
                      input logic rt, input logic [31:0] inst, input logic err);
    bit ok = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in_imm   = imm;
    bus.in_base  = base;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 32'h0, 32'h1);
    end else begin
      e.rt = rt; e.t = t; e.imm = imm; e.inst = inst; e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] fi;
    InstructionType ft;
    bit fuzz_done;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_type   = INST_TYPE_I;
    bus.in_imm    = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_err_count", {28'b0, err_count}, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Latency: output valid after the second edge.
    send(INST_TYPE_I, 32'hFFFF_FFFF, 32'h0000_0013, 0, 32'hFFF0_0013, 0);
    @(negedge clk);
    check("lat_k0_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    check("lat_k1_valid", {31'b0, bus.out_valid}, 32'h1);
    drain();

    send(INST_TYPE_B, 32'hFFFF_FFFE, 32'h0000_0063, 0, 32'hFE00_0FE3, 0);
    send(INST_TYPE_B, 32'h0000_1001, 32'h0000_0063, 0, 32'h8000_0063, 1);
    drain();
    check("err_count_1", {28'b0, err_count}, 32'h1);

    send(INST_TYPE_U, 32'h1234_5000, 32'h0000_0537, 0, 32'h1234_5537, 0);
    send(INST_TYPE_J, 32'h0010_0000, 32'h0000_006F, 0, 32'h8000_006F, 1);
    send(InstructionType'(3'd7), 32'h0000_FFFF, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
    send(INST_TYPE_U, 32'h1234_5001, 32'h0000_0537, 0, 32'h1234_5537, 1);
    drain();
    check("err_count_3", {28'b0, err_count}, 32'h3);

    // Backpressure: two beats fill the pipe, third must wait.
    bus.out_ready = 1'b0;
    send(INST_TYPE_I, 32'h0000_0005, 32'h0000_0013, 0, 32'h0050_0013, 0);
    send(INST_TYPE_I, 32'h0000_0006, 32'h0000_0013, 0, 32'h0060_0013, 0);
    bus.in_valid = 1'b1;
    bus.in_type  = INST_TYPE_S;
    bus.in_imm   = 32'hFFFF_FFF8;
    bus.in_base  = 32'h0000_2023;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
      check("stall_out_inst", bus.out_inst, 32'h0050_0013);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(INST_TYPE_S, 32'hFFFF_FFF8, 32'h0000_2023, 0, 32'hFE00_2C23, 0);
    drain();

    // Reset with two beats in flight discards them and clears the counter.
    bus.out_ready = 1'b0;
    send(INST_TYPE_B, 32'h0000_0001, 32'h0000_0063, 0, 32'h0000_0063, 1);
    send(INST_TYPE_B, 32'h0000_0001, 32'h0000_0063, 0, 32'h0000_0063, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("mid_rst_err_count", {28'b0, err_count}, 32'h0);
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Saturation of the narrow counter.
    for (int i = 0; i < 18; i++)
      send(INST_TYPE_B, 32'h0000_0001, 32'h0000_0063, 0, 32'h0000_0063, 1);
    drain();
    check("err_count_model", {28'b0, err_count}, exp_cnt);
    check("err_count_sat", {28'b0, err_count}, 32'hF);

    // Round-trip sweep with random backpressure.
    fuzz_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          r  = $urandom;
          ft = InstructionType'(3'($urandom_range(0, 4)));
          case (ft)
            INST_TYPE_I, INST_TYPE_S: fi = {{20{r[11]}}, r[11:0]};
            INST_TYPE_B: fi = {{19{r[12]}}, r[12:1], 1'b0};
            INST_TYPE_U: fi = {r[31:12], 12'b0};
            default:     fi = {{11{r[20]}}, r[20:1], 1'b0};
          endcase
          send(ft, fi, $urandom, 1, 32'h0, 0);
        end
        fuzz_done = 1;
      end
      begin
        while (!fuzz_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("final_err_count", {28'b0, err_count}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder: the inverse of `ImmGenSubmodule`. It takes an instruction type, a 32-bit immediate value and a base instruction word. It scatters the immediate into the RV32I bit positions for that type and emits the finished 32-bit instruction. It also flags immediates that the type cannot represent. It sits in the instruction-assembly and self-test path, upstream of the decoder, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `ERR_CNT_W`, default 16: width of the saturating error counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  encoder can accept an input beat this cycle.
- `in_type`  in  `InstructionType` (typedefs)  instruction type: `INST_TYPE_I`, `INST_TYPE_S`, `INST_TYPE_B`, `INST_TYPE_U`, `INST_TYPE_J`, or any other value.
- `in_imm`  in  32  immediate value, two's complement.
- `in_base`  in  32  instruction word whose non-immediate fields (opcode, rd, rs1, rs2, funct) are kept.
- `out_valid`  out  1  encoded beat valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `out_inst`  out  32  encoded instruction.
- `out_err`  out  1  the immediate was not representable; `out_inst` still carries the truncated encoding.
- `err_count`  out  `ERR_CNT_W`  number of output transfers with `out_err=1`; saturates at all-ones.

## Operation
- A transfer occurs on a side when its valid and ready are both 1 at a rising edge.
- Stage A registers `{type, imm, base}` when the input transfers.
- Stage B computes the encoding from stage A and registers `{out_inst, out_err}`.
- Each stage has its own valid bit. Stage ready = `!stage_valid || next_ready`, so the chain is combinational from `out_ready`, back through stage B, to `in_ready`.
- Field placement; every bit not listed comes from `in_base`:
  - I: inst[31:20]=imm[11:0]. Error unless imm[31:11] are all equal.
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. Error unless imm[31:11] are all equal.
  - B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]. Error if imm[0]=1, or unless imm[31:12] are all equal.
  - U: inst[31:12]=imm[31:12]. Error if imm[11:0]≠0.
  - J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]. Error if imm[0]=1, or unless imm[31:20] are all equal.
  - Any other type: out_inst=in_base, out_err=0.
- Round-trip property: for every in-range immediate, `ImmGenSubmodule` applied to `out_inst` with the same type returns `in_imm`.
- `err_count` increments by 1 on each output transfer with `out_err=1`. It holds once it reaches all-ones.
- Beats leave in acceptance order. None are dropped or duplicated.

## Timing
- Reset values (`rst=1` at an edge):
  - both stage valid bits = 0, so `out_valid`=0;
  - `out_inst`=0, `out_err`=0, `err_count`=0;
  - `in_ready`=1 in the first cycle after reset.
- Latency: an input accepted at edge k gives `out_valid`=1 after edge k+1, i.e. two cycles with `out_ready` held high.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall (`out_valid=1`, `out_ready=0`):
  - `out_inst` and `out_err` stay stable;
  - stage A can fill, so at most 2 beats are buffered;
  - `in_ready` goes low only when both stages are valid and `out_ready`=0.
- Simultaneous output transfer and input transfer in the same cycle: both stages advance. No bubble appears and no beat is lost.
- Reset mid-operation discards every in-flight beat. `err_count` clears even if an errored output transfers in that same cycle, because reset has priority.
- `in_*` signals are sampled only at the transfer edge. Changes while `in_ready`=0 have no effect.

## Test plan
- I: imm=0xFFFFFFFF, base=0x00000013 -> out_inst=0xFFF00013, out_err=0, output two cycles after acceptance.
- B: imm=0xFFFFFFFE, base=0x00000063 -> 0xFE000FE3, err=0. Then B, imm=0x00001001 -> err=1 and err_count=1 after the output transfer.
- U: imm=0x12345000, base=0x00000537 -> 0x12345537, err=0. Then J, imm=0x00100000 -> err=1.
- Backpressure: send 3 beats with out_ready=0 for 5 cycles. Required: in_ready=0 after 2 beats accepted, out_inst stable throughout, and all 3 beats emerge in order once out_ready=1.
- Reset: assert rst with 2 beats in flight -> next cycle out_valid=0, err_count=0, in_ready=1. Preload err_count near all-ones -> it saturates and does not wrap.
- Fuzz: 10^6 random (type, imm) pairs, each imm sign-extended to the type's legal range, with random out_ready. `ImmGenSubmodule` applied to out_inst must return the original imm, and err must stay 0.
